// File: rtl/regfile_arb_pkg.sv
// Shared definitions for the register-file write arbiter.
// Holds default widths, the writeback request record and the grant encodings.
package regfile_arb_pkg;

    localparam int M_DEFAULT = 32;  // write data width
    localparam int A_DEFAULT = 4;   // register address width (16 registers)

    typedef struct packed {
        logic [A_DEFAULT-1:0] addr;
        logic [M_DEFAULT-1:0] data;
    } wb_req_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_0    = 2'b01;
    localparam logic [1:0] GNT_1    = 2'b10;

endpackage

// File: rtl/rf_req_slot.sv
// One-entry writeback holding slot with valid/ready handshake.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   v, a, d         requester valid, destination register, write data
//   gnt             this slot is driving the write port this cycle
//   rdy             slot can accept this cycle (empty, or draining now)
//   acc             handshake taken on the coming edge
//   pend, addr, data  held request
module rf_req_slot #(
    parameter int M = 32,
    parameter int A = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         v,
    input  logic [A-1:0] a,
    input  logic [M-1:0] d,
    input  logic         gnt,
    output logic         rdy,
    output logic         acc,
    output logic         pend,
    output logic [A-1:0] addr,
    output logic [M-1:0] data
);

    // A draining slot may be refilled on the same edge for full throughput.
    assign rdy = !pend || gnt;
    assign acc = v && rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (acc) begin
            pend <= 1'b1;
            addr <= a;
            data <= d;
        end else if (gnt) begin
            pend <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between the ALU writeback
// (slot 0) and the memory-load writeback (slot 1). The older pending slot is
// granted; same-edge arrivals are ordered by a round-robin pointer.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   V0/A0/D0, RDY0      slot 0 request and ready
//   V1/A1/D1, RDY1      slot 1 request and ready
//   WE/WA/WD            register-file write port
//   GNT                 one-hot granted slot
// Optional (REGFILE_ARB_BYPASS_EN defined):
//   RA                  decode read address
//   BYP_HIT, BYP_DATA   pending write to RA exists / youngest such data
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int M = M_DEFAULT,
    parameter int A = A_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         V0,
    input  logic [A-1:0] A0,
    input  logic [M-1:0] D0,
    output logic         RDY0,
    input  logic         V1,
    input  logic [A-1:0] A1,
    input  logic [M-1:0] D1,
    output logic         RDY1,
    output logic         WE,
    output logic [A-1:0] WA,
    output logic [M-1:0] WD,
    output logic [1:0]   GNT
`ifdef REGFILE_ARB_BYPASS_EN
    ,
    input  logic [A-1:0] RA,
    output logic         BYP_HIT,
    output logic [M-1:0] BYP_DATA
`endif
);

    logic         pend0, pend1;
    logic         acc0, acc1;
    logic [A-1:0] addr0, addr1;
    logic [M-1:0] data0, data1;
    logic         old;  // 1: slot 1 holds the older write
    logic         rr;   // slot favoured when both arrive on one edge

    rf_req_slot #(.M(M), .A(A)) u_slot0 (
        .clk(clk), .reset(reset), .v(V0), .a(A0), .d(D0), .gnt(GNT[0]),
        .rdy(RDY0), .acc(acc0), .pend(pend0), .addr(addr0), .data(data0)
    );

    rf_req_slot #(.M(M), .A(A)) u_slot1 (
        .clk(clk), .reset(reset), .v(V1), .a(A1), .d(D1), .gnt(GNT[1]),
        .rdy(RDY1), .acc(acc1), .pend(pend1), .addr(addr1), .data(data1)
    );

    always_comb begin
        GNT = GNT_NONE;
        if (pend0 && pend1) begin
            GNT = old ? GNT_1 : GNT_0;
        end else if (pend0) begin
            GNT = GNT_0;
        end else if (pend1) begin
            GNT = GNT_1;
        end
    end

    assign WE = |GNT;

    always_comb begin
        WA = '0;
        WD = '0;
        if (GNT == GNT_0) begin
            WA = addr0;
            WD = data0;
        end else if (GNT == GNT_1) begin
            WA = addr1;
            WD = data1;
        end
    end

    // Age tracking: a slot that stays pending across an edge on which the
    // other slot is (re)filled is the older one. Simultaneous fills take
    // their order from rr, which then flips so ties alternate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            old <= 1'b0;
            rr  <= 1'b0;
        end else if (acc0 && acc1) begin
            old <= rr;
            rr  <= ~rr;
        end else if (acc0 && pend1 && !GNT[1]) begin
            old <= 1'b1;
        end else if (acc1 && pend0 && !GNT[0]) begin
            old <= 1'b0;
        end
    end

`ifdef REGFILE_ARB_BYPASS_EN
    logic hit0, hit1;

    assign hit0    = pend0 && (addr0 == RA);
    assign hit1    = pend1 && (addr1 == RA);
    assign BYP_HIT = hit0 || hit1;

    // When both slots match, the younger one carries the value that will win.
    always_comb begin
        BYP_DATA = '0;
        if (hit0 && hit1) begin
            BYP_DATA = old ? data0 : data1;
        end else if (hit0) begin
            BYP_DATA = data0;
        end else if (hit1) begin
            BYP_DATA = data1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
    import regfile_arb_pkg::*;

    localparam int M    = M_DEFAULT;
    localparam int A    = A_DEFAULT;
    localparam int NREG = 1 << A;

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic         V0    = 1'b0;
    logic [A-1:0] A0    = '0;
    logic [M-1:0] D0    = '0;
    logic         V1    = 1'b0;
    logic [A-1:0] A1    = '0;
    logic [M-1:0] D1    = '0;
    logic         RDY0, RDY1, WE;
    logic [A-1:0] WA;
    logic [M-1:0] WD;
    logic [1:0]   GNT;
`ifdef REGFILE_ARB_BYPASS_EN
    logic [A-1:0] RA = '0;
    logic         BYP_HIT;
    logic [M-1:0] BYP_DATA;
`endif

    always #5 clk = ~clk;

    regfile_write_arbiter #(.M(M), .A(A)) dut (
        .clk(clk), .reset(reset),
        .V0(V0), .A0(A0), .D0(D0), .RDY0(RDY0),
        .V1(V1), .A1(A1), .D1(D1), .RDY1(RDY1),
        .WE(WE), .WA(WA), .WD(WD), .GNT(GNT)
`ifdef REGFILE_ARB_BYPASS_EN
        , .RA(RA), .BYP_HIT(BYP_HIT), .BYP_DATA(BYP_DATA)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: every accepted write gets a sequence number; the lowest number
    // among pending slots is issued first. Same-edge pairs are numbered with
    // the round-robin favourite first.
    logic         mpend [2];
    wb_req_t      mreq  [2];
    int           mseq  [2];
    logic         mrr;
    int           nseq;
    logic [M-1:0] mrf [NREG];
    logic [M-1:0] drf [NREG];

    function automatic logic [1:0] mgnt();
        if (mpend[0] && mpend[1]) return (mseq[0] < mseq[1]) ? 2'b01 : 2'b10;
        return {mpend[1], mpend[0]};
    endfunction

    always @(posedge clk or negedge reset) begin : model
        logic [1:0] g;
        logic a0c, a1c;
        if (!reset) begin
            mpend[0] = 1'b0; mpend[1] = 1'b0;
            mreq[0]  = '0;   mreq[1]  = '0;
            mseq[0]  = 0;    mseq[1]  = 0;
            mrr      = 1'b0;
            nseq     = 0;
        end else begin
            g   = mgnt();
            a0c = V0 && (!mpend[0] || g[0]);
            a1c = V1 && (!mpend[1] || g[1]);
            if (g[0]) begin mrf[mreq[0].addr] = mreq[0].data; mpend[0] = 1'b0; end
            if (g[1]) begin mrf[mreq[1].addr] = mreq[1].data; mpend[1] = 1'b0; end
            if (a0c) begin mpend[0] = 1'b1; mreq[0].addr = A0; mreq[0].data = D0; end
            if (a1c) begin mpend[1] = 1'b1; mreq[1].addr = A1; mreq[1].data = D1; end
            if (a0c && a1c) begin
                if (!mrr) begin mseq[0] = nseq; mseq[1] = nseq + 1; end
                else      begin mseq[1] = nseq; mseq[0] = nseq + 1; end
                nseq += 2;
                mrr = ~mrr;
            end else if (a0c) begin
                mseq[0] = nseq; nseq++;
            end else if (a1c) begin
                mseq[1] = nseq; nseq++;
            end
        end
    end

    // Register file as seen through the DUT's write port.
    always @(posedge clk) begin
        if (WE) drf[WA] <= WD;
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic [1:0]   g;
        logic [A-1:0] ewa;
        logic [M-1:0] ewd;
        logic         er0, er1;
        if (reset) begin
            g   = mgnt();
            ewa = g[0] ? mreq[0].addr : (g[1] ? mreq[1].addr : '0);
            ewd = g[0] ? mreq[0].data : (g[1] ? mreq[1].data : '0);
            er0 = !mpend[0] || g[0];
            er1 = !mpend[1] || g[1];
            vectors++;
            if (WE !== (|g) || WA !== ewa || WD !== ewd || GNT !== g ||
                RDY0 !== er0 || RDY1 !== er1) begin
                miscompares++;
                $display("FAIL cycle@%0t: got WE=%b WA=%0d WD=%h GNT=%b RDY=%b%b, want WE=%b WA=%0d WD=%h GNT=%b RDY=%b%b",
                         $time, WE, WA, WD, GNT, RDY0, RDY1, |g, ewa, ewd, g, er0, er1);
            end
        end
    end

    task automatic tick(input logic v0, input logic [A-1:0] a0, input logic [M-1:0] d0,
                        input logic v1, input logic [A-1:0] a1, input logic [M-1:0] d1);
        V0 = v0; A0 = a0; D0 = d0;
        V1 = v1; A1 = a1; D1 = d1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tick(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic expect_out(input string nm, input logic we, input logic [A-1:0] wa,
                              input logic [M-1:0] wd, input logic [1:0] gnt,
                              input logic r0, input logic r1);
        vectors++;
        if (WE !== we || WA !== wa || WD !== wd || GNT !== gnt || RDY0 !== r0 || RDY1 !== r1) begin
            miscompares++;
            $display("FAIL %s: got WE=%b WA=%0d WD=%h GNT=%b RDY=%b%b, want WE=%b WA=%0d WD=%h GNT=%b RDY=%b%b",
                     nm, WE, WA, WD, GNT, RDY0, RDY1, we, wa, wd, gnt, r0, r1);
        end
    endtask

    task automatic expect_val(input string nm, input logic [M-1:0] got, input logic [M-1:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    initial begin
        for (int r = 0; r < NREG; r++) begin
            mrf[r] = '0;
            drf[r] = '0;
        end

        // Reset state
        idle();
        expect_out("reset_hold", 1'b0, '0, '0, 2'b00, 1'b1, 1'b1);
        #2 reset = 1'b1;
        idle();
        expect_out("post_reset", 1'b0, '0, '0, 2'b00, 1'b1, 1'b1);

        // Single requester streaming
        tick(1'b1, 4'd3, 32'h11, 1'b0, '0, '0);
        expect_out("stream_1", 1'b1, 4'd3, 32'h11, 2'b01, 1'b1, 1'b1);
        tick(1'b1, 4'd3, 32'h22, 1'b0, '0, '0);
        expect_out("stream_2", 1'b1, 4'd3, 32'h22, 2'b01, 1'b1, 1'b1);
        tick(1'b1, 4'd3, 32'h33, 1'b0, '0, '0);
        expect_out("stream_3", 1'b1, 4'd3, 32'h33, 2'b01, 1'b1, 1'b1);
        tick(1'b1, 4'd3, 32'h44, 1'b0, '0, '0);
        expect_out("stream_4", 1'b1, 4'd3, 32'h44, 2'b01, 1'b1, 1'b1);
        idle();
        expect_out("stream_done", 1'b0, '0, '0, 2'b00, 1'b1, 1'b1);
        expect_val("reg3_final", drf[3], 32'h44);

        // Same-edge tie, rr=0 then rr=1
        tick(1'b1, 4'd5, 32'hAAAA, 1'b1, 4'd6, 32'hBBBB);
        expect_out("tie1_first", 1'b1, 4'd5, 32'hAAAA, 2'b01, 1'b1, 1'b0);
        idle();
        expect_out("tie1_second", 1'b1, 4'd6, 32'hBBBB, 2'b10, 1'b1, 1'b1);
        idle();
        tick(1'b1, 4'd5, 32'hAAAA, 1'b1, 4'd6, 32'hBBBB);
        expect_out("tie2_first", 1'b1, 4'd6, 32'hBBBB, 2'b10, 1'b0, 1'b1);
        idle();
        expect_out("tie2_second", 1'b1, 4'd5, 32'hAAAA, 2'b01, 1'b1, 1'b1);
        idle();
        expect_out("tie2_done", 1'b0, '0, '0, 2'b00, 1'b1, 1'b1);

        // Write-after-write to reg7 with slot 0 busy
        tick(1'b1, 4'd1, 32'h99, 1'b0, '0, '0);
        expect_out("waw_busy", 1'b1, 4'd1, 32'h99, 2'b01, 1'b1, 1'b1);
        tick(1'b1, 4'd4, 32'h44, 1'b1, 4'd7, 32'h1);
        expect_out("waw_k", 1'b1, 4'd4, 32'h44, 2'b01, 1'b1, 1'b0);
        tick(1'b1, 4'd7, 32'h2, 1'b0, '0, '0);
        expect_out("waw_first", 1'b1, 4'd7, 32'h1, 2'b10, 1'b0, 1'b1);
        idle();
        expect_out("waw_second", 1'b1, 4'd7, 32'h2, 2'b01, 1'b1, 1'b1);
        idle();
        expect_val("reg7_dut", drf[7], 32'h2);
        expect_val("reg7_model", mrf[7], 32'h2);

        // Backpressure: slot 1 older, V0 held high
        tick(1'b1, 4'd8, 32'h80, 1'b1, 4'd9, 32'h90);
        expect_out("bp_stall", 1'b1, 4'd9, 32'h90, 2'b10, 1'b0, 1'b1);
        tick(1'b1, 4'd10, 32'hA0, 1'b0, '0, '0);
        expect_out("bp_grant0", 1'b1, 4'd8, 32'h80, 2'b01, 1'b1, 1'b1);
        tick(1'b1, 4'd10, 32'hA0, 1'b0, '0, '0);
        expect_out("bp_refill", 1'b1, 4'd10, 32'hA0, 2'b01, 1'b1, 1'b1);
        idle();
        expect_out("bp_done", 1'b0, '0, '0, 2'b00, 1'b1, 1'b1);

        // Reset with both slots pending
        tick(1'b1, 4'd12, 32'hC, 1'b1, 4'd13, 32'hD);
        expect_out("mid_pending", 1'b1, 4'd12, 32'hC, 2'b01, 1'b1, 1'b0);
        V0 = 1'b0; V1 = 1'b0;
        #1 reset = 1'b0;
        #1 expect_out("mid_reset", 1'b0, '0, '0, 2'b00, 1'b1, 1'b1);
        #1 reset = 1'b1;
        idle();
        expect_out("mid_after1", 1'b0, '0, '0, 2'b00, 1'b1, 1'b1);
        idle();
        expect_val("reg12_dropped", drf[12], 32'h0);
        expect_val("reg13_dropped", drf[13], 32'h0);

`ifdef REGFILE_ARB_BYPASS_EN
        tick(1'b1, 4'd2, 32'h5, 1'b1, 4'd9, 32'hC0DE);
        RA = 4'd9;
        #1 expect_val("byp_hit9", {31'd0, BYP_HIT}, 32'd1);
        expect_val("byp_data9", BYP_DATA, 32'hC0DE);
        RA = 4'd8;
        #1 expect_val("byp_miss8", {31'd0, BYP_HIT}, 32'd0);
        idle();
        idle();
`endif

        // Mixed traffic checked cycle by cycle against the model
        for (int i = 0; i < 60; i++) begin
            tick(1'($urandom_range(0, 1)), 4'($urandom_range(0, NREG - 1)), $urandom,
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, NREG - 1)), $urandom);
        end
        idle();
        idle();
        idle();
        for (int r = 0; r < NREG; r++) begin
            expect_val($sformatf("regfile_%0d", r), drf[r], mrf[r]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
